pipeline_test_sequencer: RTL

PIPELINE_TEST_SEQUENCER -- requirements
Module: pipeline_test_sequencer

---
 rtl/pipeline_test_sequencer_pkg.sv | 15 +
 rtl/pipeline_test_sequencer_watchdog.sv | 44 ++++
 rtl/pipeline_test_sequencer.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/pipeline_test_sequencer_pkg.sv
// Shared types and defaults for the pipeline test sequencer.
// Holds the sequencer state encoding and the clear-length default.
package pipeline_test_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } seq_state_e;

    localparam int CLR_CYCLES_DEF = 2;

endpackage

// File: rtl/pipeline_test_sequencer_watchdog.sv
// Output-progress watchdog for the test sequencer.
// Counts idle cycles while enabled; a zero limit disables it.
module seq_watchdog #(
    parameter int TMO_W = 16
) (
    input  logic             aclk,
    input  logic             areset,
    input  logic             en,
    input  logic             reload,
    input  logic [TMO_W-1:0] limit,
    output logic             expired
);

    localparam logic [TMO_W-1:0] ONE = TMO_W'(1);

    logic [TMO_W-1:0] cnt_q;
    logic [TMO_W-1:0] cnt_d;
    logic             armed;

    assign armed = en && (limit != '0);

    // A reload in the same cycle always beats expiry.
    assign expired = armed && !reload && (cnt_q == limit - ONE);

    // Next idle count: clear on reload, climb while armed, stop at limit.
    always_comb begin
        cnt_d = cnt_q;
        if (reload) begin
            cnt_d = '0;
        end else if (armed && (cnt_q != limit)) begin
            cnt_d = cnt_q + ONE;
        end
    end

    // Idle-count register.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pipeline_test_sequencer.sv
// Test sequencer: clears a pipeline under test, gates a run of beats,
// watches both handshakes and reports pass/timeout/data/extra results.
module pipeline_test_sequencer
    import pipeline_test_sequencer_pkg::*;
#(
    parameter int CNT_W      = 16,
    parameter int TMO_W      = 16,
    parameter int CLR_CYCLES = CLR_CYCLES_DEF
) (
    input  logic             aclk,
    input  logic             areset,
    input  logic             start,
    input  logic [CNT_W-1:0] num_txn,
    input  logic [TMO_W-1:0] timeout,
    input  logic             in_valid,
    input  logic             in_ready,
    input  logic             out_valid,
    input  logic             out_ready,
    input  logic             chk_error,
    output logic             chk_srst,
    output logic             in_en,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             tmo_err,
    output logic             data_err,
    output logic             extra_err,
    output logic [CNT_W-1:0] in_count,
    output logic [CNT_W-1:0] out_count
);

    localparam int CLR_W = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
    localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLR_CYCLES - 1);
    localparam logic [CLR_W-1:0] CLR_ONE  = CLR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    seq_state_e       state_q, state_d;
    logic [CLR_W-1:0] clr_q, clr_d;
    logic [CNT_W-1:0] num_q, num_d;
    logic [TMO_W-1:0] lim_q, lim_d;
    logic [CNT_W-1:0] in_cnt_q, in_cnt_d;
    logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
    logic             tmo_q, tmo_d;
    logic             data_q, data_d;
    logic             extra_q, extra_d;
    logic             pass_q, pass_d;
    logic             done_q, done_d;

    logic active;
    logic start_acc;
    logic run_entry;
    logic in_fire;
    logic out_fire;
    logic wd_reload;
    logic wd_expired;

    assign active    = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign start_acc = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign run_entry = (state_q == S_CLEAR) && (clr_q == CLR_LAST)
                       && (num_q != '0);

    assign in_en     = (state_q == S_RUN) && (in_cnt_q < num_q);
    assign in_fire   = in_valid && in_ready && in_en;
    assign out_fire  = out_valid && out_ready && active;
    assign wd_reload = start_acc || run_entry || out_fire;

    assign chk_srst  = (state_q == S_CLEAR);
    assign busy      = (state_q == S_CLEAR) || active;
    assign done      = done_q;
    assign pass      = pass_q;
    assign tmo_err   = tmo_q;
    assign data_err  = data_q;
    assign extra_err = extra_q;
    assign in_count  = in_cnt_q;
    assign out_count = out_cnt_q;

    seq_watchdog #(
        .TMO_W (TMO_W)
    ) u_wdog (
        .aclk    (aclk),
        .areset  (areset),
        .en      (active),
        .reload  (wd_reload),
        .limit   (lim_q),
        .expired (wd_expired)
    );

    // Next-state, counter and result-flag logic for one run.
    always_comb begin
        state_d   = state_q;
        clr_d     = clr_q;
        num_d     = num_q;
        lim_d     = lim_q;
        in_cnt_d  = in_cnt_q;
        out_cnt_d = out_cnt_q;
        tmo_d     = tmo_q;
        data_d    = data_q;
        extra_d   = extra_q;
        pass_d    = pass_q;
        done_d    = 1'b0;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d   = S_CLEAR;
                    clr_d     = '0;
                    num_d     = num_txn;
                    lim_d     = timeout;
                    in_cnt_d  = '0;
                    out_cnt_d = '0;
                    tmo_d     = 1'b0;
                    data_d    = 1'b0;
                    extra_d   = 1'b0;
                    pass_d    = 1'b0;
                end
            end
            S_CLEAR: begin
                if (clr_q == CLR_LAST) begin
                    state_d = (num_q == '0) ? S_DONE : S_RUN;
                end else begin
                    clr_d = clr_q + CLR_ONE;
                end
            end
            S_RUN, S_DRAIN: begin
                if (in_fire) begin
                    in_cnt_d = in_cnt_q + CNT_ONE;
                end
                if (out_fire) begin
                    if (out_cnt_q == num_q) begin
                        extra_d = 1'b1;
                    end
                    if (out_cnt_q != '1) begin
                        out_cnt_d = out_cnt_q + CNT_ONE;
                    end
                end
                if (chk_error) begin
                    data_d = 1'b1;
                end
                if (wd_expired) begin
                    tmo_d   = 1'b1;
                    state_d = S_DONE;
                end else if (state_q == S_RUN) begin
                    if (in_cnt_q == num_q) begin
                        state_d = S_DRAIN;
                    end
                end else if (out_cnt_d == num_q) begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if ((state_d == S_DONE) && (state_q != S_DONE)) begin
            done_d = 1'b1;
            pass_d = !tmo_d && !data_d && !extra_d && (out_cnt_d == num_q);
        end
    end

    // State, latched run parameters, counters and registered results.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q   <= S_IDLE;
            clr_q     <= '0;
            num_q     <= '0;
            lim_q     <= '0;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            tmo_q     <= 1'b0;
            data_q    <= 1'b0;
            extra_q   <= 1'b0;
            pass_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_q     <= clr_d;
            num_q     <= num_d;
            lim_q     <= lim_d;
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
            tmo_q     <= tmo_d;
            data_q    <= data_d;
            extra_q   <= extra_d;
            pass_q    <= pass_d;
            done_q    <= done_d;
        end
    end

endmodule
